// File: rtl/vga_scope_capture.sv
// Multi-channel triggered scope capture: decimates NCH ADC streams, captures NPOINTS
// samples per channel after a level trigger, then replays them as VGA plot points.
module vga_scope_capture #(
   parameter int NCH = 2,
   parameter int ADC_W = 14,
   parameter int YW = 8,
   parameter int NPOINTS = 160,
   parameter int XW = 8,
   parameter logic [12*NCH-1:0] CH_COLORS = {12'h0F0, 12'hF00},
   parameter int AUTO_TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 lock,
   input  logic [NCH*ADC_W-1:0] adc,
   input  logic [7:0]           decim,
   input  logic [1:0]           trig_ch,
   input  logic [YW-1:0]        trig_level,
   input  logic [1:0]           trig_mode,
   output logic [XW-1:0]        CounterX,
   output logic [YW-1:0]        CounterY,
   output logic [11:0]          color,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic                 triggered,
   output logic                 busy
);

   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TW  = $clog2(AUTO_TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DISPLAY} state_t;

   state_t          state_q, state_d;
   logic [7:0]      dcnt_q, dcnt_d, decim_q, decim_d;
   logic [YW-1:0]   prev_y_q, prev_y_d;
   logic            prev_vld_q, prev_vld_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [XW-1:0]   wptr_q, wptr_d, x_q, x_d, cx_q, cx_d;
   logic [CHW-1:0]  ch_q, ch_d;
   logic [YW-1:0]   cy_q, cy_d;
   logic [11:0]     color_q, color_d;
   logic            pix_valid_q, pix_valid_d, triggered_q, triggered_d, busy_q, busy_d;

   logic [YW-1:0]   sbuf_q [NCH][NPOINTS];
   logic [YW-1:0]   smp [NCH];
   logic [YW-1:0]   cur_y;
   logic            strobe, rise, fall, fire, load, wr_en;
   logic [XW-1:0]   wr_idx, rd_x;
   logic [CHW-1:0]  rd_ch;
   logic            unused_adc;

   assign unused_adc = ^adc;

   // Only the plotted (top YW) bits of each sample are kept.
   always_comb begin
      for (int i = 0; i < NCH; i++) smp[i] = adc[i*ADC_W + (ADC_W-YW) +: YW];
   end

   always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      decim_d     = decim_q;
      prev_y_d    = prev_y_q;
      prev_vld_d  = prev_vld_q;
      tcnt_d      = tcnt_q;
      wptr_d      = wptr_q;
      x_d         = x_q;
      ch_d        = ch_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      color_d     = color_q;
      pix_valid_d = pix_valid_q;
      triggered_d = triggered_q;
      busy_d      = busy_q;
      wr_en       = 1'b0;
      wr_idx      = wptr_q;
      load        = 1'b0;
      rd_x        = x_q;
      rd_ch       = ch_q;
      fire        = 1'b0;

      cur_y = smp[0];
      for (int i = 0; i < NCH; i++) if (32'(trig_ch) == i) cur_y = smp[i];
      rise = prev_vld_q && (prev_y_q < trig_level) && (cur_y >= trig_level);
      fall = prev_vld_q && (prev_y_q > trig_level) && (cur_y <= trig_level);

      // decim is latched at the wrap so a change never strands the counter above it
      strobe = (dcnt_q == decim_q);
      if (strobe) begin
         dcnt_d  = 8'd0;
         decim_d = decim;
      end else begin
         dcnt_d = dcnt_q + 8'd1;
      end

      case (state_q)
         IDLE: begin
            state_d    = ARM;
            prev_vld_d = 1'b0;
            tcnt_d     = '0;
         end
         ARM: if (strobe) begin
            prev_y_d   = cur_y;
            prev_vld_d = 1'b1;
            if (tcnt_q != TW'(AUTO_TIMEOUT-1)) tcnt_d = tcnt_q + 1'b1;
            case (trig_mode)
               2'd0:    fire = rise;
               2'd1:    fire = fall;
               2'd2:    fire = rise || (tcnt_q == TW'(AUTO_TIMEOUT-1));
               default: fire = 1'b1;
            endcase
            if (fire) begin
               state_d     = CAPTURE;
               triggered_d = 1'b1;
               busy_d      = 1'b1;
               wr_en       = 1'b1;
               wr_idx      = '0;
               wptr_d      = XW'(1);
            end
         end
         CAPTURE: if (strobe) begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + 1'b1;
            if (wptr_q == XW'(NPOINTS-1)) begin
               state_d = DISPLAY;
               wptr_d  = '0;
               x_d     = '0;
               ch_d    = '0;
            end
         end
         DISPLAY: begin
            if (!pix_valid_q) begin
               load = 1'b1;
            end else if (pix_ready) begin
               if (x_q == XW'(NPOINTS-1) && ch_q == CHW'(NCH-1)) begin
                  state_d     = ARM;
                  pix_valid_d = 1'b0;
                  triggered_d = 1'b0;
                  busy_d      = 1'b0;
                  prev_vld_d  = 1'b0;
                  tcnt_d      = '0;
               end else begin
                  load = 1'b1;
                  if (ch_q == CHW'(NCH-1)) begin
                     rd_ch = '0;
                     rd_x  = x_q + 1'b1;
                  end else begin
                     rd_ch = ch_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         x_d         = rd_x;
         ch_d        = rd_ch;
         cx_d        = rd_x;
         cy_d        = sbuf_q[rd_ch][rd_x];
         color_d     = CH_COLORS[12*rd_ch +: 12];
         pix_valid_d = 1'b1;
      end

      if (!lock) begin
         state_d     = IDLE;
         dcnt_d      = '0;
         decim_d     = '0;
         prev_y_d    = '0;
         prev_vld_d  = 1'b0;
         tcnt_d      = '0;
         wptr_d      = '0;
         x_d         = '0;
         ch_d        = '0;
         cx_d        = '0;
         cy_d        = '0;
         color_d     = '0;
         pix_valid_d = 1'b0;
         triggered_d = 1'b0;
         busy_d      = 1'b0;
         wr_en       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         dcnt_q      <= '0;
         decim_q     <= '0;
         prev_y_q    <= '0;
         prev_vld_q  <= 1'b0;
         tcnt_q      <= '0;
         wptr_q      <= '0;
         x_q         <= '0;
         ch_q        <= '0;
         cx_q        <= '0;
         cy_q        <= '0;
         color_q     <= '0;
         pix_valid_q <= 1'b0;
         triggered_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dcnt_q      <= dcnt_d;
         decim_q     <= decim_d;
         prev_y_q    <= prev_y_d;
         prev_vld_q  <= prev_vld_d;
         tcnt_q      <= tcnt_d;
         wptr_q      <= wptr_d;
         x_q         <= x_d;
         ch_q        <= ch_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         color_q     <= color_d;
         pix_valid_q <= pix_valid_d;
         triggered_q <= triggered_d;
         busy_q      <= busy_d;
      end
   end

   // Sample buffer holds data only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < NCH; i++) sbuf_q[i][wr_idx] <= smp[i];
      end
   end

   assign CounterX  = cx_q;
   assign CounterY  = cy_q;
   assign color     = color_q;
   assign pix_valid = pix_valid_q;
   assign triggered = triggered_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_vga_scope_capture.sv
// Directed bench for vga_scope_capture: trigger modes, decimation, replay order,
// backpressure, lock drop and asynchronous reset.
module tb_vga_scope_capture;
   localparam int NCH = 2, ADC_W = 14, YW = 8, NPOINTS = 160, XW = 8;
   localparam int NPTS = NCH * NPOINTS;

   logic clk = 1'b0;
   logic reset, lock, pix_ready, pix_valid, triggered, busy;
   logic [NCH*ADC_W-1:0] adc;
   logic [7:0] decim, trig_level, CounterX, CounterY;
   logic [1:0] trig_ch, trig_mode;
   logic [11:0] color;

   int n_cmp = 0, n_bad = 0;
   int px[NPTS], py[NPTS], pc[NPTS];
   int npix, nstall, stab_err;
   bit tmo;

   always #5 clk = ~clk;

   vga_scope_capture #(.NCH(NCH), .ADC_W(ADC_W), .YW(YW), .NPOINTS(NPOINTS), .XW(XW),
      .CH_COLORS({12'h0F0, 12'hF00}), .AUTO_TIMEOUT(1024)) dut (
      .clk(clk), .reset(reset), .lock(lock), .adc(adc), .decim(decim), .trig_ch(trig_ch),
      .trig_level(trig_level), .trig_mode(trig_mode), .CounterX(CounterX), .CounterY(CounterY),
      .color(color), .pix_valid(pix_valid), .pix_ready(pix_ready), .triggered(triggered),
      .busy(busy));

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_adc(input logic [7:0] y0, input logic [7:0] y1);
      adc = {y1, 6'd0, y0, 6'd0};
   endtask

   // kind 0: ch0 ramps +1/clk from start, ch1 = 0x55; kind 1: ch0 = 0x11, ch1 square C0/20 (4 clk halves)
   task automatic drive_wave(input int kind, input int start, input int cycles);
      logic [7:0] v;
      for (int c = 0; c < cycles; c++) begin
         v = 8'(start + c);
         if (kind == 0) set_adc(v, 8'h55);
         else set_adc(8'h11, ((c / 4) % 2 == 1) ? 8'h20 : 8'hC0);
         if (busy) trig_mode = 2'd0;
         tick();
      end
   endtask

   task automatic collect(input int stall_pct);
      bit pend;
      logic [7:0] sx, sy;
      logic [11:0] sc;
      int cyc;
      pend = 0; cyc = 0; npix = 0; nstall = 0; stab_err = 0; tmo = 0;
      sx = '0; sy = '0; sc = '0;
      while (npix < NPTS) begin
         if (cyc >= 6000) begin tmo = 1; break; end
         tick(); cyc++;
         if (pend && !(pix_valid && CounterX == sx && CounterY == sy && color == sc)) stab_err++;
         pix_ready = ($urandom_range(0, 99) >= stall_pct);
         pend = 0;
         if (pix_valid) begin
            if (pix_ready) begin
               px[npix] = CounterX; py[npix] = CounterY; pc[npix] = color; npix++;
            end else begin
               pend = 1; sx = CounterX; sy = CounterY; sc = color; nstall++;
            end
         end
      end
      if (!tmo) tick();
      pix_ready = 1'b0;
   endtask

   function automatic int order_errs();
      int e = 0;
      for (int i = 0; i < NPTS; i++)
         if (px[i] != i / 2 || pc[i] != (((i % 2) == 0) ? 12'hF00 : 12'h0F0)) e++;
      return e;
   endfunction

   task automatic test_reset;
      reset = 1; lock = 0; pix_ready = 0; decim = 0; trig_ch = 0;
      trig_level = 8'h80; trig_mode = 0; set_adc(8'h00, 8'h00);
      tick(2);
      n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%0b want=0", pix_valid); end
      n_cmp++; if (triggered !== 1'b0) begin n_bad++; $display("FAIL rst_trig got=%0b want=0", triggered); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
      n_cmp++; if (CounterX !== 8'h00) begin n_bad++; $display("FAIL rst_x got=%0h want=0", CounterX); end
      reset = 0; lock = 1;
      tick(3);
      n_cmp++; if (busy !== 1'b0 || triggered !== 1'b0) begin n_bad++; $display("FAIL arm_idle busy=%0b trig=%0b want 0/0", busy, triggered); end
   endtask

   task automatic test_rising;
      int e0, e1;
      for (int r = 0; r < 200; r++) begin
         set_adc(8'(8'h70 + r), 8'h55);
         tick();
         if (r == 15) begin n_cmp++; if (triggered !== 1'b0) begin n_bad++; $display("FAIL rise_early got=%0b want=0", triggered); end end
         if (r == 16) begin n_cmp++; if (triggered !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rise_fire trig=%0b busy=%0b want 1/1", triggered, busy); end end
         if (r == 175) begin n_cmp++; if (pix_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL rise_capend valid=%0b busy=%0b want 0/1", pix_valid, busy); end end
         if (r == 176) begin
            n_cmp++;
            if (pix_valid !== 1'b1 || CounterX !== 8'h00 || CounterY !== 8'h80 || color !== 12'hF00) begin
               n_bad++; $display("FAIL rise_first v=%0b x=%0h y=%0h c=%0h want 1/0/80/F00", pix_valid, CounterX, CounterY, color);
            end
         end
      end
      collect(0);
      n_cmp++; if (tmo || npix != NPTS) begin n_bad++; $display("FAIL rise_count got=%0d want=%0d", npix, NPTS); end
      n_cmp++; if (order_errs() != 0) begin n_bad++; $display("FAIL rise_order errs=%0d want=0", order_errs()); end
      e0 = 0; e1 = 0;
      for (int x = 0; x < NPOINTS; x++) begin
         if (py[2*x] != ((8'h80 + x) & 8'hFF)) e0++;
         if (py[2*x+1] != 8'h55) e1++;
      end
      n_cmp++; if (e0 != 0) begin n_bad++; $display("FAIL rise_ch0_data errs=%0d want=0", e0); end
      n_cmp++; if (e1 != 0) begin n_bad++; $display("FAIL rise_ch1_data errs=%0d want=0", e1); end
      n_cmp++; if (pix_valid !== 1'b0 || triggered !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rise_done v=%0b t=%0b b=%0b want 0/0/0", pix_valid, triggered, busy); end
   endtask

   task automatic test_decimation;
      int e;
      decim = 8'd3; trig_mode = 0; set_adc(8'h00, 8'h55);
      tick(8);
      trig_mode = 3;
      fork
         drive_wave(0, 0, 700);
         collect(0);
      join
      n_cmp++; if (tmo || npix != NPTS) begin n_bad++; $display("FAIL dec_count got=%0d want=%0d", npix, NPTS); end
      e = 0;
      for (int x = 1; x < NPOINTS; x++) if (((py[2*x] - py[2*x-2]) & 8'hFF) != 4) e++;
      n_cmp++; if (e != 0) begin n_bad++; $display("FAIL dec_step errs=%0d want=0", e); end
      decim = 8'd0;
      tick(6);
   endtask

   task automatic test_back_to_back;
      int e;
      trig_mode = 3;
      fork
         drive_wave(0, 8'h30, 300);
         collect(50);
      join
      n_cmp++; if (tmo || npix != NPTS) begin n_bad++; $display("FAIL bp_count got=%0d want=%0d", npix, NPTS); end
      n_cmp++; if (order_errs() != 0) begin n_bad++; $display("FAIL bp_order errs=%0d want=0", order_errs()); end
      n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL bp_stable errs=%0d want=0", stab_err); end
      n_cmp++; if (nstall == 0) begin n_bad++; $display("FAIL bp_stalls got=%0d want>0", nstall); end
      e = 0;
      for (int x = 1; x < NPOINTS; x++) if (((py[2*x] - py[2*x-2]) & 8'hFF) != 1) e++;
      n_cmp++; if (e != 0) begin n_bad++; $display("FAIL bp_step errs=%0d want=0", e); end
      n_cmp++; if (px[NPTS-1] != 159 || pc[NPTS-1] != 12'h0F0) begin n_bad++; $display("FAIL bp_last x=%0d c=%0h want 159/0F0", px[NPTS-1], pc[NPTS-1]); end
      n_cmp++; if (busy !== 1'b0 || triggered !== 1'b0) begin n_bad++; $display("FAIL bp_rearm b=%0b t=%0b want 0/0", busy, triggered); end
   endtask

   task automatic test_auto;
      trig_mode = 2; trig_level = 8'h80; set_adc(8'h10, 8'h10);
      lock = 0; tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL auto_idle busy=%0b want=0", busy); end
      lock = 1; tick();
      tick(1023);
      n_cmp++; if (triggered !== 1'b0) begin n_bad++; $display("FAIL auto_early got=%0b want=0", triggered); end
      tick();
      n_cmp++; if (triggered !== 1'b1) begin n_bad++; $display("FAIL auto_fire got=%0b want=1", triggered); end
      trig_mode = 0;
      collect(0);
      n_cmp++; if (tmo || npix != NPTS || py[0] != 8'h10) begin n_bad++; $display("FAIL auto_data n=%0d y0=%0h want %0d/10", npix, py[0], NPTS); end
   endtask

   task automatic test_freerun_lock;
      trig_mode = 3;
      lock = 0; tick(); lock = 1; tick();
      n_cmp++; if (triggered !== 1'b0) begin n_bad++; $display("FAIL free_entry got=%0b want=0", triggered); end
      tick();
      n_cmp++; if (triggered !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL free_fire t=%0b b=%0b want 1/1", triggered, busy); end
      tick(5);
      lock = 0; tick();
      n_cmp++; if (busy !== 1'b0 || triggered !== 1'b0) begin n_bad++; $display("FAIL lock_drop b=%0b t=%0b want 0/0", busy, triggered); end
      lock = 1; tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lock_arm busy=%0b want=0", busy); end
      tick();
      n_cmp++; if (triggered !== 1'b1) begin n_bad++; $display("FAIL lock_rearm got=%0b want=1", triggered); end
      trig_mode = 0;
      collect(0);
      n_cmp++; if (tmo || npix != NPTS) begin n_bad++; $display("FAIL free_count got=%0d want=%0d", npix, NPTS); end
   endtask

   task automatic test_falling;
      trig_ch = 1; trig_mode = 1; trig_level = 8'h80;
      lock = 0; tick(); lock = 1;
      fork
         drive_wave(1, 0, 400);
         collect(0);
      join
      n_cmp++; if (tmo || npix != NPTS) begin n_bad++; $display("FAIL fall_count got=%0d want=%0d", npix, NPTS); end
      n_cmp++; if (py[1] != 8'h20) begin n_bad++; $display("FAIL fall_idx0 got=%0h want=20", py[1]); end
      n_cmp++; if (py[0] != 8'h11) begin n_bad++; $display("FAIL fall_ch0 got=%0h want=11", py[0]); end
      n_cmp++; if (py[7] != 8'h20 || py[9] != 8'hC0) begin n_bad++; $display("FAIL fall_wave y3=%0h y4=%0h want 20/C0", py[7], py[9]); end
      trig_ch = 0; trig_mode = 0;
   endtask

   task automatic test_reset_display;
      int w;
      set_adc(8'h10, 8'h22); trig_mode = 3;
      lock = 0; tick(); lock = 1; tick(3);
      trig_mode = 0;
      w = 0;
      while (!pix_valid && w < 400) begin tick(); w++; end
      n_cmp++; if (pix_valid !== 1'b1) begin n_bad++; $display("FAIL rd_display got=%0b want=1", pix_valid); end
      pix_ready = 1; tick(9); pix_ready = 0;
      n_cmp++; if (CounterX !== 8'd4 || color !== 12'h0F0) begin n_bad++; $display("FAIL rd_point x=%0d c=%0h want 4/0F0", CounterX, color); end
      #2 reset = 1;
      #1;
      n_cmp++;
      if (pix_valid !== 1'b0 || CounterX !== 8'h00 || triggered !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL async_rst v=%0b x=%0h t=%0b b=%0b want 0/0/0/0", pix_valid, CounterX, triggered, busy);
      end
      tick();
      reset = 0;
   endtask

   initial begin
      test_reset();
      test_rising();
      test_decimation();
      test_back_to_back();
      test_auto();
      test_freerun_lock();
      test_falling();
      test_reset_display();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/vga_scope_capture.md
Name: vga_scope_capture

Overview:
- Parametrised multi-channel successor to the single-channel free-running VGA trace generator.
- Decimates NCH ADC streams, waits for a level trigger on a selectable channel, and captures NPOINTS samples per channel into an internal buffer.
- Then replays the buffer as (CounterX, CounterY, color) plot points over a valid/ready handshake to the VGA frame-buffer writer.
- Re-arms after each replay, so the displayed trace is stable rather than rolling.

Parameters:
- NCH, 2, number of ADC channels (1..4)
- ADC_W, 14, width of each ADC sample
- YW, 8, plotted Y width; CounterY = sample[ADC_W-1 -: YW]
- NPOINTS, 160, samples captured per channel (X range 0..NPOINTS-1)
- XW, 8, CounterX width; must satisfy 2^XW >= NPOINTS
- CH_COLORS, {12'h0F0,12'hF00}, packed 12-bit colour per channel; channel 0 in the LSBs
- AUTO_TIMEOUT, 1024, decimated samples waited in auto mode before a forced trigger

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- lock  input  1  PLL lock / enable; low forces IDLE
- adc  input  NCH*ADC_W  channel samples, channel 0 in the LSBs; sampled every clk
- decim  input  8  sample taken every decim+1 clocks
- trig_ch  input  2  trigger source channel; values >= NCH select channel 0
- trig_level  input  YW  trigger threshold, compared against the plotted (top YW) bits
- trig_mode  input  2  0 = rising, 1 = falling, 2 = auto (rising, or timeout), 3 = free-run
- CounterX  output  XW  plot X
- CounterY  output  YW  plot Y
- color  output  12  plot colour
- pix_valid  output  1  point valid
- pix_ready  input  1  consumer accepts the point
- triggered  output  1  high from the trigger until replay completes
- busy  output  1  high in CAPTURE or DISPLAY

Behaviour:
- Reset (async) and lock=0 (synchronous, any state): state=IDLE; all outputs 0; decim counter, write pointer and timeout counter cleared.
- Decimation: counter runs 0..decim. A sample strobe fires when the counter equals decim, and the counter then wraps to 0. decim=0 gives a strobe every clk. A change of decim takes effect at the next wrap.
- States:
  - IDLE -> ARM on the first clk with lock=1.
  - ARM: on each strobe, register the previous trigger-channel Y (prev_y).
    - Rising trigger: prev_y < trig_level and cur_y >= trig_level.
    - Falling trigger: prev_y > trig_level and cur_y <= trig_level.
    - prev_y is invalid for the first strobe after entering ARM, so no trigger can fire on that strobe.
    - Mode 2 also triggers when the timeout counter reaches AUTO_TIMEOUT-1.
    - Mode 3 triggers on the first strobe.
    - On trigger: go to CAPTURE, set triggered=1. The triggering strobe's samples are written to index 0.
  - CAPTURE: on each strobe, write all NCH samples (top YW bits only) at wptr, then wptr++. After index NPOINTS-1 is written, go to DISPLAY with x=0, ch=0.
  - DISPLAY: present the point for buffer[ch][x]: CounterX=x, CounterY=stored Y, color=CH_COLORS[ch].
    - pix_valid rises at most 1 clk after entering DISPLAY (buffer read latency 1).
    - Outputs stay stable while pix_valid && !pix_ready.
    - On acceptance, advance ch first, then x (channel-interleaved order).
    - The next point is valid no later than 1 clk after acceptance; back-to-back throughput of 1 point per clk is allowed.
    - After point (NPOINTS-1, NCH-1) is accepted: pix_valid=0, triggered=0, go to ARM.
- ADC samples arriving during DISPLAY are ignored; the buffer is never written outside CAPTURE.
- Changes to trig_mode, trig_level or trig_ch are sampled only in ARM.
- CounterX never exceeds NPOINTS-1. No wrap occurs mid-replay.
- busy = (state==CAPTURE || state==DISPLAY).

Test Plan:
- Reset and lock: assert reset mid-DISPLAY -> pix_valid, CounterX, triggered and busy are 0 immediately (async). Drop lock for 1 clk mid-CAPTURE -> IDLE, then a fresh ARM.
- Rising trigger: NCH=2, decim=0, trig_level=8'h80, ch0 ramp 8'h70..8'hFF by 1/clk -> trigger when ch0 goes 7F->80. Replay order is (0,ch0=80,F00), (0,ch1,0F0), (1,ch0=81,F00), ... for 320 points.
- Decimation: decim=3, ramp by 1/clk -> stored ch0 Y values step by 4 across X.
- Backpressure: pix_ready toggles 1/0 with random stalls -> no point lost or duplicated; outputs stable during stalls; last point is X=159, ch1, and the block returns to ARM.
- Auto/free-run: mode 2 with constant ADC 8'h10 and level 8'h80 -> forced trigger exactly AUTO_TIMEOUT strobes after ARM. Mode 3 -> capture starts on the first strobe.
- Falling trigger on ch1 (trig_ch=1): ch1 square wave 8'hC0/8'h20 -> capture index 0 holds 8'h20.
